// File: rtl/edge_event_detector_if.sv
// Control/readout bundle of the multi-channel edge event detector.
// The master side drives triggers and controls; the slave side is the detector.
interface edge_event_detector_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8
);
    logic                    locked;
    logic [1:0]              edge_sel;
    logic [N_CH-1:0]         tin;
    logic [N_CH-1:0]         clr;
    logic [N_CH-1:0]         tout;
    logic [N_CH-1:0]         flag;
    logic [N_CH*CNT_W-1:0]   evt_cnt;

    modport master (
        output locked, edge_sel, tin, clr,
        input  tout, flag, evt_cnt
    );

    modport slave (
        input  locked, edge_sel, tin, clr,
        output tout, flag, evt_cnt
    );
endinterface

// File: rtl/edge_event_detector.sv
// Per-channel synchroniser, glitch filter and edge detector with a sticky flag
// and a saturating event counter; filtering and detection pause while the PLL is unlocked.
module edge_event_detector #(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYC    = 4,
    parameter int CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 nrst,
    edge_event_detector_if.slave bus
);
    localparam int             CW       = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;
    localparam logic [CW-1:0]  STAB_MAX = CW'(FILT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [N_CH-1:0]       sync_q [SYNC_STAGES];
    logic [N_CH-1:0]       s;
    logic [N_CH-1:0]       filt_q;
    logic [CW-1:0]         stab_q [N_CH];
    logic [N_CH-1:0]       upd;
    logic [N_CH-1:0]       qual;
    logic [N_CH-1:0]       tout_q;
    logic [N_CH-1:0]       flag_q;
    logic [N_CH*CNT_W-1:0] cnt_q;

    assign s = sync_q[SYNC_STAGES-1];

    // NOTE: the synchroniser chain is reset like any other flop so that s[] is
    // defined from the first cycle; non-blocking assignments keep each stage one edge apart.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= bus.tin;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    // NOTE: every always_comb output is given a default before the loop so no latch is inferred.
    always_comb begin
        upd  = '0;
        qual = '0;
        for (int i = 0; i < N_CH; i++) begin
            upd[i]  = bus.locked && (s[i] != filt_q[i]) && (stab_q[i] == STAB_MAX);
            // The new filtered level equals s[i]: high means a rise, low a fall.
            qual[i] = upd[i] && (s[i] ? bus.edge_sel[0] : bus.edge_sel[1]);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            filt_q <= '0;
            for (int i = 0; i < N_CH; i++) stab_q[i] <= '0;
        end else if (bus.locked) begin
            for (int i = 0; i < N_CH; i++) begin
                if (s[i] == filt_q[i]) begin
                    stab_q[i] <= '0;
                end else if (upd[i]) begin
                    filt_q[i] <= s[i];
                    stab_q[i] <= '0;
                end else begin
                    stab_q[i] <= stab_q[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            tout_q <= '0;
            flag_q <= '0;
            cnt_q  <= '0;
        end else begin
            tout_q <= qual;
            flag_q <= (flag_q & ~bus.clr) | qual;
            for (int i = 0; i < N_CH; i++) begin
                // A clear coinciding with an event restarts the count at one.
                if (bus.clr[i]) begin
                    cnt_q[i*CNT_W +: CNT_W] <= qual[i] ? CNT_W'(1) : '0;
                end else if (qual[i] && (cnt_q[i*CNT_W +: CNT_W] != CNT_MAX)) begin
                    cnt_q[i*CNT_W +: CNT_W] <= cnt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
                end
            end
        end
    end

    assign bus.tout    = tout_q;
    assign bus.flag    = flag_q;
    assign bus.evt_cnt = cnt_q;
endmodule

// File: tb/tb_edge_event_detector.sv
// Directed testbench for edge_event_detector with default parameters.
// Inputs change 1 ns after a rising edge; outputs are sampled at that same point.
module tb_edge_event_detector;
    logic clk;
    logic nrst;
    int   n_tests;
    int   n_fail;
    int   pulses;

    edge_event_detector_if #(.N_CH(4), .CNT_W(8)) bus ();

    edge_event_detector #(
        .N_CH(4), .SYNC_STAGES(2), .FILT_CYC(4), .CNT_W(8)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [7:0] cnt_of(input int ch);
        return bus.evt_cnt[ch*8 +: 8];
    endfunction

    initial begin
        n_tests = 0;
        n_fail  = 0;
        nrst         = 1'b0;
        bus.locked   = 1'b0;
        bus.edge_sel = 2'b00;
        bus.tin      = '0;
        bus.clr      = '0;
        tick(2);
        check("reset_tout", bus.tout, 0);
        check("reset_flag", bus.flag, 0);
        check("reset_cnt", bus.evt_cnt, 0);
        nrst         = 1'b1;
        bus.locked   = 1'b1;
        bus.edge_sel = 2'b01;
        tick(4);

        // Rising edge on channel 0: pulse after edge 6, gone after edge 7.
        bus.tin[0] = 1'b1;
        tick(5);
        check("rise0_e5", bus.tout, 0);
        tick(1);
        check("rise0_e6", bus.tout, 4'b0001);
        check("rise0_flag", bus.flag, 4'b0001);
        check("rise0_cnt0", cnt_of(0), 1);
        check("rise0_cnt_others", bus.evt_cnt[31:8], 0);
        tick(1);
        check("rise0_e7", bus.tout, 0);

        // Falling-only: a 3-cycle glitch is rejected, an 8-cycle pulse yields one fall event.
        bus.edge_sel = 2'b10;
        bus.tin[1] = 1'b1;
        tick(3);
        bus.tin[1] = 1'b0;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            if (bus.tout[1]) pulses++;
        end
        check("glitch1_pulses", pulses, 0);
        check("glitch1_cnt", cnt_of(1), 0);
        bus.tin[1] = 1'b1;
        tick(8);
        bus.tin[1] = 1'b0;
        pulses = 0;
        for (int k = 0; k < 14; k++) begin
            tick(1);
            if (bus.tout[1]) pulses++;
        end
        check("fall1_pulses", pulses, 1);
        check("fall1_cnt", cnt_of(1), 1);
        check("fall1_flag", bus.flag[1], 1);

        // Both edges, 300 events on channel 2: counter saturates.
        bus.edge_sel = 2'b11;
        for (int t = 0; t < 300; t++) begin
            bus.tin[2] = ~bus.tin[2];
            tick(10);
        end
        check("sat2_cnt", cnt_of(2), 255);
        check("sat2_flag", bus.flag[2], 1);
        bus.clr[2] = 1'b1;
        tick(1);
        bus.clr[2] = 1'b0;
        check("clr2_cnt", cnt_of(2), 0);
        check("clr2_flag", bus.flag[2], 0);
        bus.clr[2] = 1'b1;
        bus.tin[2] = 1'b1;
        tick(6);
        check("clrevt2_tout", bus.tout[2], 1);
        check("clrevt2_cnt", cnt_of(2), 1);
        check("clrevt2_flag", bus.flag[2], 1);
        bus.clr[2] = 1'b0;
        tick(1);
        check("clrevt2_hold_cnt", cnt_of(2), 1);

        // Lock lost for 5 cycles after 2 filter cycles on channel 3.
        bus.edge_sel = 2'b01;
        bus.tin[3] = 1'b1;
        tick(4);
        bus.locked = 1'b0;
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            if (bus.tout != 0) pulses++;
        end
        check("unlocked_no_tout", pulses, 0);
        bus.locked = 1'b1;
        tick(1);
        check("relock3_e1", bus.tout[3], 0);
        tick(1);
        check("relock3_e2", bus.tout[3], 1);
        check("relock3_cnt", cnt_of(3), 1);

        // All four channels rise together.
        bus.tin = 4'b0000;
        tick(10);
        bus.tin = 4'b1111;
        tick(6);
        check("all_rise_tout", bus.tout, 4'b1111);
        check("all_rise_cnt0", cnt_of(0), 2);
        tick(1);
        check("all_rise_after", bus.tout, 0);

        // Reset mid-window, then a fresh event after release.
        bus.tin = 4'b0000;
        tick(10);
        bus.tin = 4'b1111;
        tick(3);
        nrst = 1'b0;
        #1;
        check("rst_mid_tout", bus.tout, 0);
        check("rst_mid_flag", bus.flag, 0);
        check("rst_mid_cnt", bus.evt_cnt, 0);
        tick(3);
        check("rst_hold_tout", bus.tout, 0);
        nrst = 1'b1;
        tick(5);
        check("post_rst_e5", bus.tout, 0);
        tick(1);
        check("post_rst_e6", bus.tout, 4'b1111);
        check("post_rst_flag", bus.flag, 4'b1111);
        check("post_rst_cnt", bus.evt_cnt, 32'h0101_0101);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
